// File: rtl/ram_cmd_pkg.sv
// Shared command format, opcodes, arbiter states and owner tags for RAM access.
package ram_cmd_pkg;

   localparam int unsigned OP_W   = 2;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned CMD_W  = OP_W + DATA_W;

   localparam logic [OP_W-1:0] OP_WR_ADDR = 2'b00;
   localparam logic [OP_W-1:0] OP_WR_DATA = 2'b01;
   localparam logic [OP_W-1:0] OP_RD_ADDR = 2'b10;
   localparam logic [OP_W-1:0] OP_RD_CMD  = 2'b11;

   localparam logic OWNER_SPI  = 1'b0;
   localparam logic OWNER_HOST = 1'b1;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] payload;
   } ram_cmd_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOCK_SPI  = 2'd1,
      LOCK_HOST = 2'd2,
      WAIT_RD   = 2'd3
   } arb_state_t;

   // Address-phase opcodes open (or refresh) a lock on the RAM.
   function automatic logic is_lock_op(input logic [OP_W-1:0] op);
      return (op == OP_WR_ADDR) || (op == OP_RD_ADDR);
   endfunction

endpackage

// File: rtl/ram_access_arbiter_spi_cmd_buffer.sv
// One-entry holding buffer for SPI commands that cannot issue on arrival.
module spi_cmd_buffer
   import ram_cmd_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [CMD_W-1:0] wr_data,
   input  logic             wr_en,
   input  logic             drain,
   output logic [CMD_W-1:0] data,
   output logic             valid,
   output logic             overflow_c
);

   // A write only lands when the slot is free or being emptied this cycle.
   assign overflow_c = wr_en & valid & ~drain;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (wr_en && (!valid || drain)) begin
         valid <= 1'b1;
         data  <= wr_data;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ram_access_arbiter.sv
// Arbitrates the single-port RAM between the SPI slave and the host port,
// holding address/data pairs atomic and steering read data back to its requester.
module ram_access_arbiter
   import ram_cmd_pkg::*;
#(
   parameter int unsigned LOCK_TIMEOUT = 64,
   parameter int unsigned CNT_W        = $clog2(LOCK_TIMEOUT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CMD_W-1:0]  spi_rx_data,
   input  logic              spi_rx_valid,
   output logic [DATA_W-1:0] spi_tx_data,
   output logic              spi_tx_valid,
   input  logic [CMD_W-1:0]  host_cmd,
   input  logic              host_valid,
   output logic              host_ready,
   output logic [DATA_W-1:0] host_rd_data,
   output logic              host_rd_valid,
   output logic [CMD_W-1:0]  ram_din,
   output logic              ram_rx_valid,
   input  logic [DATA_W-1:0] ram_dout,
   input  logic              ram_tx_valid,
   input  logic              status_clr,
   output logic              spi_overflow,
   output logic              lock_timeout
);

   arb_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             owner, owner_nxt;

   logic             buf_valid;
   logic [CMD_W-1:0] buf_data;
   logic             buf_drain;
   logic             overflow_c;

   ram_cmd_t         issue_cmd;
   logic             issue;
   logic             issue_src;
   logic             live_issue;
   logic             host_xfer;
   logic             route_spi;
   logic             route_host;
   logic             timeout_evt;
   logic             cnt_clr;
   logic             cnt_max;

   assign host_ready = ~rst & (((state == IDLE) & ~buf_valid & ~spi_rx_valid) |
                               (state == LOCK_HOST));
   assign host_xfer  = host_valid & host_ready;
   assign cnt_max    = (cnt == CNT_W'(LOCK_TIMEOUT - 1));

   spi_cmd_buffer u_spi_buf (
      .clk        (clk),
      .rst        (rst),
      .wr_data    (spi_rx_data),
      .wr_en      (spi_rx_valid & ~live_issue),
      .drain      (buf_drain),
      .data       (buf_data),
      .valid      (buf_valid),
      .overflow_c (overflow_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         owner <= OWNER_SPI;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         owner <= owner_nxt;
      end
   end

   // Source selection, lock transitions and timeout.
   always_comb begin
      state_nxt   = state;
      owner_nxt   = owner;
      issue       = 1'b0;
      issue_src   = OWNER_SPI;
      issue_cmd   = '0;
      live_issue  = 1'b0;
      buf_drain   = 1'b0;
      route_spi   = 1'b0;
      route_host  = 1'b0;
      timeout_evt = 1'b0;
      cnt_clr     = 1'b0;

      case (state)
         IDLE, LOCK_SPI: begin
            if (buf_valid) begin
               issue     = 1'b1;
               issue_cmd = buf_data;
               buf_drain = 1'b1;
            end else if (spi_rx_valid) begin
               issue      = 1'b1;
               issue_cmd  = spi_rx_data;
               live_issue = 1'b1;
            end else if (host_xfer) begin
               issue     = 1'b1;
               issue_cmd = host_cmd;
               issue_src = OWNER_HOST;
            end
         end
         LOCK_HOST: begin
            if (host_xfer) begin
               issue     = 1'b1;
               issue_cmd = host_cmd;
               issue_src = OWNER_HOST;
            end
         end
         WAIT_RD: begin
            if (ram_tx_valid) begin
               route_spi  = (owner == OWNER_SPI);
               route_host = (owner == OWNER_HOST);
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (issue) begin
         if (is_lock_op(issue_cmd.op)) begin
            state_nxt = (issue_src == OWNER_HOST) ? LOCK_HOST : LOCK_SPI;
            cnt_clr   = 1'b1;
         end else if (issue_cmd.op == OP_RD_CMD) begin
            state_nxt = WAIT_RD;
            owner_nxt = issue_src;
            cnt_clr   = 1'b1;
         end else begin
            state_nxt = IDLE;
         end
      end

      // Returned read data takes precedence over an expiring wait.
      if ((state != IDLE) && cnt_max && !(state == WAIT_RD && ram_tx_valid)) begin
         state_nxt   = IDLE;
         timeout_evt = 1'b1;
      end

      if ((state == IDLE) || cnt_clr || (state_nxt == IDLE)) begin
         cnt_nxt = '0;
      end else begin
         cnt_nxt = cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ram_din       <= '0;
         ram_rx_valid  <= 1'b0;
         spi_tx_data   <= '0;
         spi_tx_valid  <= 1'b0;
         host_rd_data  <= '0;
         host_rd_valid <= 1'b0;
         spi_overflow  <= 1'b0;
         lock_timeout  <= 1'b0;
      end else begin
         ram_din       <= issue ? issue_cmd : '0;
         ram_rx_valid  <= issue;
         spi_tx_data   <= route_spi ? ram_dout : '0;
         spi_tx_valid  <= route_spi;
         host_rd_data  <= route_host ? ram_dout : '0;
         host_rd_valid <= route_host;
         spi_overflow  <= overflow_c  | (spi_overflow & ~status_clr);
         lock_timeout  <= timeout_evt | (lock_timeout & ~status_clr);
      end
   end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter: expected RAM commands and read returns
// are queued as stimulus is driven and compared as the DUT emits them.
module tb_ram_access_arbiter;
   import ram_cmd_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  spi_rx_data;
   logic        spi_rx_valid;
   logic [7:0]  spi_tx_data;
   logic        spi_tx_valid;
   logic [9:0]  host_cmd;
   logic        host_valid;
   logic        host_ready;
   logic [7:0]  host_rd_data;
   logic        host_rd_valid;
   logic [9:0]  ram_din;
   logic        ram_rx_valid;
   logic [7:0]  ram_dout;
   logic        ram_tx_valid;
   logic        status_clr;
   logic        spi_overflow;
   logic        lock_timeout;

   int checks   = 0;
   int failures = 0;

   logic [9:0] exp_ram[$];
   logic [7:0] exp_host[$];
   logic [7:0] exp_spi[$];

   always #5 clk = ~clk;

   ram_access_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .spi_rx_data   (spi_rx_data),
      .spi_rx_valid  (spi_rx_valid),
      .spi_tx_data   (spi_tx_data),
      .spi_tx_valid  (spi_tx_valid),
      .host_cmd      (host_cmd),
      .host_valid    (host_valid),
      .host_ready    (host_ready),
      .host_rd_data  (host_rd_data),
      .host_rd_valid (host_rd_valid),
      .ram_din       (ram_din),
      .ram_rx_valid  (ram_rx_valid),
      .ram_dout      (ram_dout),
      .ram_tx_valid  (ram_tx_valid),
      .status_clr    (status_clr),
      .spi_overflow  (spi_overflow),
      .lock_timeout  (lock_timeout)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (ram_rx_valid) begin
         check_eq("ram_issue_expected", 32'(exp_ram.size() != 0), 32'd1);
         if (exp_ram.size() != 0) check_eq("ram_din", 32'(ram_din), 32'(exp_ram.pop_front()));
      end
      if (host_rd_valid) begin
         check_eq("host_rd_expected", 32'(exp_host.size() != 0), 32'd1);
         if (exp_host.size() != 0) check_eq("host_rd_data", 32'(host_rd_data), 32'(exp_host.pop_front()));
      end
      if (spi_tx_valid) begin
         check_eq("spi_tx_expected", 32'(exp_spi.size() != 0), 32'd1);
         if (exp_spi.size() != 0) check_eq("spi_tx_data", 32'(spi_tx_data), 32'(exp_spi.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic spi_send(input logic [9:0] cmd);
      spi_rx_data  = cmd;
      spi_rx_valid = 1'b1;
      tick();
      spi_rx_valid = 1'b0;
      spi_rx_data  = '0;
   endtask

   task automatic host_send(input logic [9:0] cmd);
      logic done;
      done       = 1'b0;
      host_cmd   = cmd;
      host_valid = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (host_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      host_valid = 1'b0;
      host_cmd   = '0;
      check_eq("host_accept", 32'(done), 32'd1);
   endtask

   task automatic ram_return(input logic [7:0] data);
      ram_dout     = data;
      ram_tx_valid = 1'b1;
      tick();
      ram_tx_valid = 1'b0;
      ram_dout     = '0;
   endtask

   initial begin
      logic early;
      rst          = 1'b1;
      spi_rx_data  = '0;
      spi_rx_valid = 1'b0;
      host_cmd     = '0;
      host_valid   = 1'b0;
      ram_dout     = '0;
      ram_tx_valid = 1'b0;
      status_clr   = 1'b0;
      repeat (3) tick();

      // Reset values
      check_eq("rst_ram_rx_valid", 32'(ram_rx_valid), 32'd0);
      check_eq("rst_ram_din", 32'(ram_din), 32'd0);
      check_eq("rst_host_ready", 32'(host_ready), 32'd0);
      check_eq("rst_flags", 32'({spi_overflow, lock_timeout, spi_tx_valid, host_rd_valid}), 32'd0);
      rst = 1'b0;
      tick();
      check_eq("idle_host_ready", 32'(host_ready), 32'd1);

      // SPI write pair, one-cycle issue latency
      exp_ram.push_back(10'h005);
      spi_send(10'h005);
      check_eq("t1_addr_valid", 32'(ram_rx_valid), 32'd1);
      check_eq("t1_addr_din", 32'(ram_din), 32'h005);
      check_eq("t1_locked_host_ready", 32'(host_ready), 32'd0);
      exp_ram.push_back(10'h1A5);
      spi_send(10'h1A5);
      check_eq("t1_data_din", 32'(ram_din), 32'h1A5);
      tick();
      check_eq("t1_idle_host_ready", 32'(host_ready), 32'd1);

      // Host read returns to host only
      exp_ram.push_back(10'h212);
      host_send(10'h212);
      exp_ram.push_back(10'h300);
      host_send(10'h300);
      check_eq("t2_wait_host_ready", 32'(host_ready), 32'd0);
      exp_host.push_back(8'h3C);
      ram_return(8'h3C);
      check_eq("t2_host_rd_valid", 32'(host_rd_valid), 32'd1);
      check_eq("t2_host_rd_data", 32'(host_rd_data), 32'h3C);
      check_eq("t2_spi_tx_quiet", 32'(spi_tx_valid), 32'd0);
      tick();
      check_eq("t2_host_rd_pulse", 32'(host_rd_valid), 32'd0);

      // Host lock buffers SPI; pending issues before a simultaneous live command
      exp_ram.push_back(10'h010);
      host_send(10'h010);
      spi_send(10'h077);
      check_eq("t3_buffered_no_issue", 32'(ram_rx_valid), 32'd0);
      exp_ram.push_back(10'h155);
      host_send(10'h155);
      exp_ram.push_back(10'h077);
      exp_ram.push_back(10'h0CC);
      spi_send(10'h0CC);
      check_eq("t3_pending_first", 32'(ram_din), 32'h077);
      tick();
      check_eq("t3_live_after", 32'(ram_din), 32'h0CC);
      exp_ram.push_back(10'h1DD);
      spi_send(10'h1DD);
      tick();
      check_eq("t3_no_overflow", 32'(spi_overflow), 32'd0);
      check_eq("t3_idle", 32'(host_ready), 32'd1);

      // Overflow: second SPI command during host lock is dropped
      exp_ram.push_back(10'h010);
      host_send(10'h010);
      spi_send(10'h001);
      check_eq("t4_first_kept", 32'(spi_overflow), 32'd0);
      spi_send(10'h002);
      check_eq("t4_overflow_set", 32'(spi_overflow), 32'd1);
      exp_ram.push_back(10'h1BB);
      exp_ram.push_back(10'h001);
      host_send(10'h1BB);
      tick();
      check_eq("t4_buffered_issue", 32'(ram_din), 32'h001);
      check_eq("t4_overflow_sticky", 32'(spi_overflow), 32'd1);
      status_clr = 1'b1;
      tick();
      status_clr = 1'b0;
      check_eq("t4_overflow_clr", 32'(spi_overflow), 32'd0);
      exp_ram.push_back(10'h1EE);
      spi_send(10'h1EE);
      tick();

      // Lock timeout after exactly LOCK_TIMEOUT cycles
      exp_ram.push_back(10'h2FF);
      spi_send(10'h2FF);
      early = 1'b0;
      repeat (63) begin
         tick();
         if (lock_timeout || host_ready) early = 1'b1;
      end
      check_eq("t5_no_early_release", 32'(early), 32'd0);
      tick();
      check_eq("t5_lock_timeout", 32'(lock_timeout), 32'd1);
      check_eq("t5_host_ready_back", 32'(host_ready), 32'd1);
      status_clr = 1'b1;
      tick();
      status_clr = 1'b0;
      check_eq("t5_timeout_clr", 32'(lock_timeout), 32'd0);

      // SPI read returns to SPI only
      exp_ram.push_back(10'h2AA);
      spi_send(10'h2AA);
      exp_ram.push_back(10'h300);
      spi_send(10'h300);
      exp_spi.push_back(8'h5A);
      ram_return(8'h5A);
      check_eq("t5b_spi_tx_valid", 32'(spi_tx_valid), 32'd1);
      check_eq("t5b_spi_tx_data", 32'(spi_tx_data), 32'h5A);
      check_eq("t5b_host_quiet", 32'(host_rd_valid), 32'd0);
      tick();

      // Reset in WAIT_RD discards the outstanding read
      exp_ram.push_back(10'h300);
      host_send(10'h300);
      rst = 1'b1;
      tick();
      check_eq("t6_rst_ram_rx_valid", 32'(ram_rx_valid), 32'd0);
      check_eq("t6_rst_ram_din", 32'(ram_din), 32'd0);
      check_eq("t6_rst_host_ready", 32'(host_ready), 32'd0);
      rst = 1'b0;
      ram_return(8'h55);
      check_eq("t6_late_host_rd", 32'(host_rd_valid), 32'd0);
      check_eq("t6_late_spi_tx", 32'(spi_tx_valid), 32'd0);
      tick();
      check_eq("t6_idle_after", 32'(host_ready), 32'd1);

      repeat (3) tick();
      check_eq("sb_ram_drained", 32'(exp_ram.size()), 32'd0);
      check_eq("sb_host_drained", 32'(exp_host.size()), 32'd0);
      check_eq("sb_spi_drained", 32'(exp_spi.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
